// File: rtl/rs_group_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_group_scheduler_if
// Description : Bundle of the issue, RS-line, functional-unit and CDB signals
//               seen by one reservation-station group scheduler.
//               master : the scheduler side (drives issue strobes, FU operands,
//                        CDB request/drive and line release strobes).
//               slave  : the environment side (decode, RS lines, FU, CDB
//                        arbiter).
//               Port summary (scheduler view):
//                 in  issue_req, rs_busy[N], rs_ready[N], rs_v1/rs_v2[32*N],
//                     fu_done, fu_result[32], cdb_grant
//                 out issue_ok, issue_sel[N], issue_tag[8], fu_start,
//                     fu_a/fu_b[32], cdb_req, cdb_out[41], result_taken[N]
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_group_scheduler_if #(
    parameter int N = 4
);
    logic             issue_req;
    logic             issue_ok;
    logic [N-1:0]     issue_sel;
    logic [7:0]       issue_tag;

    logic [N-1:0]     rs_busy;
    logic [N-1:0]     rs_ready;
    logic [32*N-1:0]  rs_v1;
    logic [32*N-1:0]  rs_v2;

    logic             fu_start;
    logic [31:0]      fu_a;
    logic [31:0]      fu_b;
    logic             fu_done;
    logic [31:0]      fu_result;

    logic             cdb_req;
    logic             cdb_grant;
    logic [40:0]      cdb_out;
    logic [N-1:0]     result_taken;

    modport master (
        input  issue_req, rs_busy, rs_ready, rs_v1, rs_v2,
               fu_done, fu_result, cdb_grant,
        output issue_ok, issue_sel, issue_tag, fu_start, fu_a, fu_b,
               cdb_req, cdb_out, result_taken
    );

    modport slave (
        output issue_req, rs_busy, rs_ready, rs_v1, rs_v2,
               fu_done, fu_result, cdb_grant,
        input  issue_ok, issue_sel, issue_tag, fu_start, fu_a, fu_b,
               cdb_req, cdb_out, result_taken
    );
endinterface
`default_nettype wire

// File: rtl/rs_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_group_scheduler
// Description : Controller for one group of N reservation-station lines that
//               share a single non-pipelined functional unit. Steers issues to
//               the lowest free line, picks a ready line round-robin, runs it
//               through the FU, requests the CDB and releases the line once
//               the broadcast is granted. One op in flight at a time.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - rs_group_scheduler_if.master (issue, RS lines, FU, CDB)
// Revision    : 1.0 - initial release
// ============================================================================
module rs_group_scheduler #(
    parameter int         N        = 4,
    parameter logic [7:0] TAG_BASE = 8'h01
) (
    input  wire logic               clk,
    input  wire logic               rst,
    rs_group_scheduler_if.master    bus
);

    localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_EXEC     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_CDB = 2'd2;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_sel;
    logic [31:0]         r_res;
    logic                r_fu_start;
    logic [31:0]         r_fu_a;
    logic [31:0]         r_fu_b;
    logic                r_cdb_req;

    // ------------------------------------------------------------------------
    // Issue steering: lowest-index non-busy line, independent of FSM state
    // ------------------------------------------------------------------------
    logic [c_IDX_W-1:0]  w_issue_idx;
    logic                w_issue_any;

    always_comb begin
        w_issue_idx = '0;
        w_issue_any = 1'b0;
        // Scan downward so the lowest free index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!bus.rs_busy[i]) begin
                w_issue_idx = c_IDX_W'(i);
                w_issue_any = 1'b1;
            end
        end
    end

    assign bus.issue_ok  = w_issue_any;
    assign bus.issue_sel = (bus.issue_req && w_issue_any)
                         ? ({{(N-1){1'b0}}, 1'b1} << w_issue_idx)
                         : '0;
    assign bus.issue_tag = TAG_BASE + 8'(w_issue_idx);

    // ------------------------------------------------------------------------
    // Round-robin pick. The ready vector is rotated so that bit 0 corresponds
    // to r_rr_ptr; the first set bit of the rotated vector is the offset from
    // the pointer, which is then added back modulo N.
    // ------------------------------------------------------------------------
    logic [N-1:0]        w_ready_rot;
    logic [c_IDX_W-1:0]  w_off;
    logic [c_IDX_W:0]    w_sum;
    logic [c_IDX_W-1:0]  w_pick_idx;
    logic                w_pick_any;
    logic [c_IDX_W-1:0]  w_rr_next;

    always_comb begin
        w_ready_rot = N'({bus.rs_ready, bus.rs_ready} >> r_rr_ptr);
        w_off       = '0;
        w_pick_any  = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_ready_rot[j]) begin
                w_off      = c_IDX_W'(j);
                w_pick_any = 1'b1;
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (c_IDX_W+1)'(N)) begin
            w_sum = w_sum - (c_IDX_W+1)'(N);
        end
        w_pick_idx = w_sum[c_IDX_W-1:0];
        w_rr_next  = (w_pick_idx == c_IDX_W'(N - 1)) ? '0
                                                     : w_pick_idx + c_IDX_W'(1);
    end

    // Operand mux for the picked line.
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick_idx == c_IDX_W'(i)) begin
                w_op_a = bus.rs_v1[32*i +: 32];
                w_op_b = bus.rs_v2[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Dispatch / execute / broadcast FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_res      <= '0;
            r_fu_start <= 1'b0;
            r_fu_a     <= '0;
            r_fu_b     <= '0;
            r_cdb_req  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_fu_start <= 1'b0;
                    if (w_pick_any) begin
                        r_sel      <= w_pick_idx;
                        r_fu_a     <= w_op_a;
                        r_fu_b     <= w_op_b;
                        r_fu_start <= 1'b1;
                        r_rr_ptr   <= w_rr_next;
                        r_state    <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_fu_start <= 1'b0;
                    // A done coincident with our own start pulse cannot belong
                    // to this op, so the first honoured done is one cycle later.
                    if (bus.fu_done && !r_fu_start) begin
                        r_res     <= bus.fu_result;
                        r_cdb_req <= 1'b1;
                        r_state   <= c_ST_WAIT_CDB;
                    end
                end
                c_ST_WAIT_CDB: begin
                    if (bus.cdb_grant) begin
                        r_cdb_req <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. CDB drive and line release are valid in the grant cycle itself.
    // ------------------------------------------------------------------------
    logic w_granted;
    assign w_granted = (r_state == c_ST_WAIT_CDB) && bus.cdb_grant;

    assign bus.fu_start     = r_fu_start;
    assign bus.fu_a         = r_fu_a;
    assign bus.fu_b         = r_fu_b;
    assign bus.cdb_req      = r_cdb_req;
    assign bus.cdb_out      = w_granted ? {1'b1, TAG_BASE + 8'(r_sel), r_res} : '0;
    assign bus.result_taken = w_granted ? ({{(N-1){1'b0}}, 1'b1} << r_sel) : '0;

endmodule
`default_nettype wire

// File: tb/tb_rs_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_group_scheduler
// Description : Self-checking bench for rs_group_scheduler (N=4, TAG_BASE=1).
//               The bench plays the RS lines, the FU and the CDB arbiter, and
//               keeps a line-level model (busy/ready/operands per line plus a
//               round-robin pointer) from which every expectation is derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_group_scheduler;

    localparam int         N        = 4;
    localparam logic [7:0] TAG_BASE = 8'h01;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rs_group_scheduler_if #(.N(N)) bus ();

    rs_group_scheduler #(.N(N), .TAG_BASE(TAG_BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Line-level reference model
    bit          m_busy  [N];
    bit          m_ready [N];
    logic [31:0] m_v1    [N];
    logic [31:0] m_v2    [N];
    int          m_rr;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.rs_busy[i]        = m_busy[i];
            bus.rs_ready[i]       = m_ready[i];
            bus.rs_v1[32*i +: 32] = m_v1[i];
            bus.rs_v2[32*i +: 32] = m_v2[i];
        end
        #1;
    endtask

    function automatic int model_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < N; k++) if (m_ready[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_ready[i] = 0; m_v1[i] = '0; m_v2[i] = '0;
        end
        m_rr = 0;
    endtask

    task automatic chk_issue(input bit req);
        int          e;
        logic [63:0] exp_sel;
        e = model_free();
        exp_sel = '0;
        if (req && e >= 0) exp_sel = 64'(1) << e;
        chk("issue_ok", 64'(bus.issue_ok), 64'(e >= 0));
        chk("issue_sel", 64'(bus.issue_sel), exp_sel);
        if (e >= 0) chk("issue_tag", 64'(bus.issue_tag), 64'(8'(int'(TAG_BASE) + e)));
    endtask

    // One complete op from the IDLE decision cycle to the cycle after release.
    task automatic run_op(input int lat, input int gdly, input bit done_on_grant,
                          input bit req_issue, input bit refill, input logic [31:0] res);
        int          p;
        int          e;
        logic [63:0] exp_cdb;
        p = model_pick();
        bus.issue_req = req_issue;
        #1;
        chk_issue(req_issue);
        chk("fu_start_pre", 64'(bus.fu_start), 64'(0));
        tick();
        if (req_issue) begin
            e = model_free();
            if (e >= 0) begin
                m_busy[e] = 1; m_ready[e] = 0; m_v1[e] = $urandom; m_v2[e] = $urandom;
            end
        end
        bus.issue_req = 1'b0;
        apply();
        chk("fu_start", 64'(bus.fu_start), 64'(1));
        chk("fu_a", 64'(bus.fu_a), 64'(m_v1[p]));
        chk("fu_b", 64'(bus.fu_b), 64'(m_v2[p]));
        m_rr = (p + 1) % N;
        tick();
        chk("fu_start_pulse", 64'(bus.fu_start), 64'(0));
        chk("cdb_req_exec", 64'(bus.cdb_req), 64'(0));
        for (int c = 1; c < lat; c++) tick();
        bus.fu_done   = 1'b1;
        bus.fu_result = res;
        tick();
        bus.fu_done   = 1'b0;
        bus.fu_result = $urandom;
        #1;
        chk("cdb_req_set", 64'(bus.cdb_req), 64'(1));
        for (int g = 0; g < gdly; g++) begin
            chk("cdb_req_hold", 64'(bus.cdb_req), 64'(1));
            chk("cdb_out_nogrant", 64'(bus.cdb_out), 64'(0));
            chk("taken_nogrant", 64'(bus.result_taken), 64'(0));
            tick();
        end
        bus.cdb_grant = 1'b1;
        bus.fu_done   = done_on_grant;
        #1;
        exp_cdb = {23'b0, 1'b1, 8'(int'(TAG_BASE) + p), res};
        chk("cdb_out", 64'(bus.cdb_out), exp_cdb);
        chk("result_taken", 64'(bus.result_taken), 64'(1) << p);
        tick();
        bus.cdb_grant = 1'b0;
        bus.fu_done   = 1'b0;
        m_busy[p] = 0; m_ready[p] = 0;
        if (refill) begin
            m_busy[p] = 1; m_ready[p] = 1; m_v1[p] = $urandom; m_v2[p] = $urandom;
        end
        apply();
        chk("cdb_req_clr", 64'(bus.cdb_req), 64'(0));
        chk("cdb_out_clr", 64'(bus.cdb_out), 64'(0));
        chk("taken_clr", 64'(bus.result_taken), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.issue_req = 1'b0;
        bus.fu_done   = 1'b0;
        bus.fu_result = '0;
        bus.cdb_grant = 1'b0;
        model_reset();
        apply();

        // Reset state
        chk("rst_fu_start", 64'(bus.fu_start), 64'(0));
        chk("rst_fu_a", 64'(bus.fu_a), 64'(0));
        chk("rst_fu_b", 64'(bus.fu_b), 64'(0));
        chk("rst_cdb_req", 64'(bus.cdb_req), 64'(0));
        chk("rst_cdb_out", 64'(bus.cdb_out), 64'(0));
        chk("rst_taken", 64'(bus.result_taken), 64'(0));
        tick();
        rst = 1'b0;

        // Issue steering: fill all four lines, then no more room
        for (int k = 0; k < N; k++) begin
            bus.issue_req = 1'b1;
            #1;
            chk_issue(1'b1);
            tick();
            m_busy[k] = 1;
            m_v1[k] = $urandom;
            m_v2[k] = $urandom;
            apply();
        end
        bus.issue_req = 1'b1;
        #1;
        chk_issue(1'b1);
        bus.issue_req = 1'b0;

        // Line 2 ready with 5/7, result 12, granted on first request
        m_ready[2] = 1; m_v1[2] = 32'd5; m_v2[2] = 32'd7;
        apply();
        run_op(2, 0, 1'b0, 1'b0, 1'b0, 32'd12);

        // Lines 0 and 1 ready continuously: alternation 0,1,0,1...
        m_ready[0] = 1; m_ready[1] = 1;
        apply();
        for (int r = 0; r < 6; r++) run_op(1, 0, 1'b0, 1'b0, 1'b1, $urandom);

        // Grant withheld five cycles
        run_op(3, 5, 1'b0, 1'b0, 1'b1, $urandom);

        // fu_done while idle is ignored
        for (int i = 0; i < N; i++) m_ready[i] = 0;
        apply();
        bus.fu_done   = 1'b1;
        bus.fu_result = 32'hDEAD_BEEF;
        tick();
        bus.fu_done = 1'b0;
        #1;
        chk("idle_done_req", 64'(bus.cdb_req), 64'(0));
        chk("idle_done_start", 64'(bus.fu_start), 64'(0));
        tick();
        chk("idle_done_req2", 64'(bus.cdb_req), 64'(0));

        // fu_done coincident with grant has no effect on the next op
        m_busy[3] = 1; m_ready[3] = 1; m_v1[3] = $urandom; m_v2[3] = $urandom;
        apply();
        run_op(2, 1, 1'b1, 1'b0, 1'b0, $urandom);
        tick();
        chk("after_grant_done_req", 64'(bus.cdb_req), 64'(0));

        // Reset during EXEC
        m_busy[1] = 1; m_ready[1] = 1; m_v1[1] = 32'h1111_2222; m_v2[1] = 32'h3333_4444;
        apply();
        tick();
        chk("pre_rst_start", 64'(bus.fu_start), 64'(1));
        rst = 1'b1;
        model_reset();
        apply();
        chk("mid_rst_fu_start", 64'(bus.fu_start), 64'(0));
        chk("mid_rst_fu_a", 64'(bus.fu_a), 64'(0));
        chk("mid_rst_fu_b", 64'(bus.fu_b), 64'(0));
        chk("mid_rst_cdb_req", 64'(bus.cdb_req), 64'(0));
        chk("mid_rst_cdb_out", 64'(bus.cdb_out), 64'(0));
        chk("mid_rst_taken", 64'(bus.result_taken), 64'(0));
        tick();
        rst = 1'b0;
        bus.fu_done   = 1'b1;
        bus.fu_result = 32'h5A5A_5A5A;
        tick();
        bus.fu_done = 1'b0;
        #1;
        chk("post_rst_done_req", 64'(bus.cdb_req), 64'(0));

        // Randomized ops against the line model
        for (int t = 0; t < 25; t++) begin
            int any;
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        m_busy[i]  = 1;
                        m_ready[i] = bit'($urandom_range(0, 1));
                        m_v1[i] = $urandom; m_v2[i] = $urandom;
                    end
                end else if (!m_ready[i] && $urandom_range(0, 1) == 1) begin
                    m_ready[i] = 1;
                end
                if (m_ready[i]) any = 1;
            end
            if (any == 0) begin
                int s;
                s = $urandom_range(0, N - 1);
                m_busy[s] = 1; m_ready[s] = 1; m_v1[s] = $urandom; m_v2[s] = $urandom;
            end
            apply();
            run_op($urandom_range(1, 4), $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), 1'b0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
